bvh_traverse_stream: RTL and testbench

//  Parametrised next-generation BVH traversal engine for RayCore. Walks a binary BVH from root (index 0) with an

---
 rtl/bvh_traverse_stream.sv | 210 +++++++++++++++++++++
 tb/tb_bvh_traverse_stream.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bvh_traverse_stream.sv
// Binary BVH traversal: LIFO node stack, variable-latency node fetch, leaf-range pairs streamed downstream.
// Latency: >=3 cycles per node (FETCH, EVAL, POP), plus one EMIT cycle and any stall when a leaf pair is produced.
// Backpressure: out_valid/out_* hold in EMIT until out_ready; node fetching pauses meanwhile.
module bvh_traverse_stream #(
    parameter int NODE_W      = 16,
    parameter int STACK_DEPTH = 16,
    parameter int PRIM_IDX_W  = 16,
    parameter int PRIM_CNT_W  = 8,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    near_first,
    output logic                    node_req,
    output logic [NODE_W-1:0]       node_req_idx,
    input  logic                    node_rsp_valid,
    input  logic [2*NODE_W-1:0]     node_child,
    input  logic                    node_hit,
    input  logic [1:0]              leaf_hit,
    input  logic [2*PRIM_IDX_W-1:0] leaf_start,
    input  logic [2*PRIM_CNT_W-1:0] leaf_num,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*PRIM_IDX_W-1:0] out_start_prim,
    output logic [2*PRIM_CNT_W-1:0] out_num_prim,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [CNT_W-1:0]        node_count
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0]       DEPTH_C   = SP_W'(STACK_DEPTH);
    localparam logic [NODE_W-1:0]     NULL_NODE = '1;
    localparam logic [PRIM_IDX_W-1:0] NULL_PRIM = '1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_EMIT, S_POP, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [SP_W-1:0]         sp_q, sp_d;
    logic [NODE_W-1:0]       stack_q [STACK_DEPTH];
    logic [NODE_W-1:0]       stack_d [STACK_DEPTH];
    logic [NODE_W-1:0]       req_idx_q, req_idx_d;
    logic                    near_q, near_d;
    logic [2*NODE_W-1:0]     child_q, child_d;
    logic                    nhit_q, nhit_d;
    logic [1:0]              lhit_q, lhit_d;
    logic [2*PRIM_IDX_W-1:0] lstart_q, lstart_d;
    logic [2*PRIM_CNT_W-1:0] lnum_q, lnum_d;
    logic [2*PRIM_IDX_W-1:0] ostart_q, ostart_d;
    logic [2*PRIM_CNT_W-1:0] onum_q, onum_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NODE_W-1:0] child0, child1, near_c, far_c;
    logic [1:0]        slot_vld;

    assign child0 = child_q[NODE_W-1:0];
    assign child1 = child_q[2*NODE_W-1:NODE_W];
    assign near_c = near_q ? child1 : child0;
    assign far_c  = near_q ? child0 : child1;
    // A slot carries a range only for a real (non-null) leaf that was hit and holds primitives.
    assign slot_vld[0] = nhit_q & lhit_q[0] & child0[NODE_W-1] & (child0 != NULL_NODE)
                         & (lnum_q[PRIM_CNT_W-1:0] != '0);
    assign slot_vld[1] = nhit_q & lhit_q[1] & child1[NODE_W-1] & (child1 != NULL_NODE)
                         & (lnum_q[2*PRIM_CNT_W-1:PRIM_CNT_W] != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            sp_q      <= '0;
            req_idx_q <= '0;
            near_q    <= 1'b0;
            child_q   <= '0;
            nhit_q    <= 1'b0;
            lhit_q    <= '0;
            lstart_q  <= '0;
            lnum_q    <= '0;
            ostart_q  <= {2{NULL_PRIM}};
            onum_q    <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            req_idx_q <= req_idx_d;
            near_q    <= near_d;
            child_q   <= child_d;
            nhit_q    <= nhit_d;
            lhit_q    <= lhit_d;
            lstart_q  <= lstart_d;
            lnum_q    <= lnum_d;
            ostart_q  <= ostart_d;
            onum_q    <= onum_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_FETCH;
                S_FETCH:        if (node_rsp_valid) state_d = S_EVAL;
                S_EVAL:         state_d = (|slot_vld) ? S_EMIT : S_POP;
                S_EMIT:         if (out_ready) state_d = S_POP;
                S_POP:          state_d = (sp_q == '0) ? S_DONE : S_FETCH;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sp_d      = sp_q;
        stack_d   = stack_q;
        req_idx_d = req_idx_q;
        near_d    = near_q;
        child_d   = child_q;
        nhit_d    = nhit_q;
        lhit_d    = lhit_q;
        lstart_d  = lstart_q;
        lnum_d    = lnum_q;
        ostart_d  = ostart_q;
        onum_d    = onum_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        if (abort) begin
            sp_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sp_d      = '0;
                        ovf_d     = 1'b0;
                        cnt_d     = '0;
                        near_d    = near_first;
                        req_idx_d = '0;
                    end
                end
                S_FETCH: begin
                    if (node_rsp_valid) begin
                        child_d  = node_child;
                        nhit_d   = node_hit;
                        lhit_d   = leaf_hit;
                        lstart_d = leaf_start;
                        lnum_d   = leaf_num;
                        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    // Far child goes in first so the near child sits on top; the second push sees the updated sp.
                    if (nhit_q && !far_c[NODE_W-1]) begin
                        if (sp_d < DEPTH_C) begin
                            stack_d[sp_d[IDX_W-1:0]] = far_c;
                            sp_d = sp_d + SP_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (nhit_q && !near_c[NODE_W-1]) begin
                        if (sp_d < DEPTH_C) begin
                            stack_d[sp_d[IDX_W-1:0]] = near_c;
                            sp_d = sp_d + SP_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (|slot_vld) begin
                        ostart_d[PRIM_IDX_W-1:0] = slot_vld[0] ? lstart_q[PRIM_IDX_W-1:0] : NULL_PRIM;
                        ostart_d[2*PRIM_IDX_W-1:PRIM_IDX_W] =
                            slot_vld[1] ? lstart_q[2*PRIM_IDX_W-1:PRIM_IDX_W] : NULL_PRIM;
                        onum_d[PRIM_CNT_W-1:0] = slot_vld[0] ? lnum_q[PRIM_CNT_W-1:0] : '0;
                        onum_d[2*PRIM_CNT_W-1:PRIM_CNT_W] =
                            slot_vld[1] ? lnum_q[2*PRIM_CNT_W-1:PRIM_CNT_W] : '0;
                    end
                end
                S_POP: begin
                    if (sp_q != '0) begin
                        sp_d      = sp_q - SP_W'(1);
                        req_idx_d = stack_q[sp_d[IDX_W-1:0]];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        node_req  = (state_q == S_FETCH);
        out_valid = (state_q == S_EMIT);
        busy      = (state_q == S_FETCH) || (state_q == S_EVAL) || (state_q == S_EMIT) || (state_q == S_POP);
        done      = (state_q == S_DONE);
    end

    assign node_req_idx   = req_idx_q;
    assign out_start_prim = ostart_q;
    assign out_num_prim   = onum_q;
    assign overflow       = ovf_q;
    assign node_count     = cnt_q;

endmodule

// File: tb/tb_bvh_traverse_stream.sv
// Bench for bvh_traverse_stream: random and directed trees served by a random-latency node memory,
// results compared with a stack-walk reference model of the traversal rules.
module tb_bvh_traverse_stream;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn, start, abort, near_first;
    logic        node_req;
    logic [15:0] node_req_idx;
    logic        node_rsp_valid;
    logic [31:0] node_child;
    logic        node_hit;
    logic [1:0]  leaf_hit;
    logic [31:0] leaf_start;
    logic [15:0] leaf_num;
    logic        out_valid, out_ready;
    logic [31:0] out_start_prim;
    logic [15:0] out_num_prim;
    logic        busy, done, overflow;
    logic [15:0] node_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] t_c0 [16];
    logic [15:0] t_c1 [16];
    logic        t_nh [16];
    logic [1:0]  t_lh [16];
    logic [15:0] t_ls0 [16];
    logic [15:0] t_ls1 [16];
    logic [7:0]  t_ln0 [16];
    logic [7:0]  t_ln1 [16];

    int          exp_fetch [$];
    logic [47:0] exp_pair [$];
    logic        exp_ovf;
    int          exp_cnt;

    always #5 clk = ~clk;

    bvh_traverse_stream #(.STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .near_first(near_first),
        .node_req(node_req), .node_req_idx(node_req_idx), .node_rsp_valid(node_rsp_valid),
        .node_child(node_child), .node_hit(node_hit), .leaf_hit(leaf_hit), .leaf_start(leaf_start),
        .leaf_num(leaf_num), .out_valid(out_valid), .out_ready(out_ready),
        .out_start_prim(out_start_prim), .out_num_prim(out_num_prim), .busy(busy), .done(done),
        .overflow(overflow), .node_count(node_count)
    );

    task automatic clear_tree();
        for (int i = 0; i < 16; i++) begin
            t_c0[i] = 16'hFFFF; t_c1[i] = 16'hFFFF; t_nh[i] = 1'b0; t_lh[i] = 2'b00;
            t_ls0[i] = 16'd0; t_ls1[i] = 16'd0; t_ln0[i] = 8'd0; t_ln1[i] = 8'd0;
        end
    endtask

    function automatic logic [15:0] rand_child(input int i);
        int r;
        r = $urandom_range(0, 9);
        if (r < 4 && i < 15) return 16'($urandom_range(i + 1, (i + 4 > 15) ? 15 : i + 4));
        if (r < 9) return 16'h8000 | 16'($urandom_range(0, 32767));
        return 16'hFFFF;
    endfunction

    task automatic gen_tree();
        for (int i = 0; i < 16; i++) begin
            t_nh[i]  = ($urandom_range(0, 3) != 0);
            t_lh[i]  = 2'($urandom_range(0, 3));
            t_ls0[i] = 16'($urandom); t_ls1[i] = 16'($urandom);
            t_ln0[i] = 8'($urandom_range(0, 3)); t_ln1[i] = 8'($urandom_range(0, 3));
            t_c0[i]  = rand_child(i); t_c1[i] = rand_child(i);
        end
    endtask

    function automatic logic slot_ok(input logic [15:0] c, input logic h, input logic [7:0] n);
        return h && c[15] && (c != 16'hFFFF) && (n != 8'd0);
    endfunction

    // Depth-first walk: the near child is visited before the far child, pushes beyond DEPTH are lost.
    task automatic run_model(input bit nf);
        int          stk [$];
        int          cur;
        logic [15:0] ord [2];
        logic        v0, v1;
        exp_fetch.delete(); exp_pair.delete(); exp_ovf = 1'b0; cur = 0;
        while (1) begin
            exp_fetch.push_back(cur);
            if (t_nh[cur]) begin
                ord[0] = nf ? t_c0[cur] : t_c1[cur];
                ord[1] = nf ? t_c1[cur] : t_c0[cur];
                for (int k = 0; k < 2; k++) begin
                    if (!ord[k][15]) begin
                        if (stk.size() < DEPTH) stk.push_back(int'(ord[k]));
                        else exp_ovf = 1'b1;
                    end
                end
                v0 = slot_ok(t_c0[cur], t_lh[cur][0], t_ln0[cur]);
                v1 = slot_ok(t_c1[cur], t_lh[cur][1], t_ln1[cur]);
                if (v0 || v1)
                    exp_pair.push_back({v1 ? t_ls1[cur] : 16'hFFFF, v1 ? t_ln1[cur] : 8'd0,
                                        v0 ? t_ls0[cur] : 16'hFFFF, v0 ? t_ln0[cur] : 8'd0});
            end
            if (stk.size() == 0) break;
            cur = stk.pop_back();
        end
        exp_cnt = exp_fetch.size();
    endtask

    task automatic drive_node(input int i);
        node_child = {t_c1[i], t_c0[i]};
        node_hit   = t_nh[i];
        leaf_hit   = t_lh[i];
        leaf_start = {t_ls1[i], t_ls0[i]};
        leaf_num   = {t_ln1[i], t_ln0[i]};
    endtask

    // mode 0: random out_ready, 1: always ready, 2: ready only on the 11th cycle of each pair
    task automatic run_ray(input bit nf, input int mode, input string tag);
        int          got_f [$];
        logic [47:0] got_p [$];
        bit          pending, fin, just_hs;
        int          lat, waited, hold, cyc;
        logic [15:0] held_idx;
        logic [47:0] prev_o, cur_o;
        run_model(nf);
        pending = 0; fin = 0; just_hs = 0; hold = 0; cyc = 0; lat = 0; waited = 0;
        held_idx = '0; prev_o = '0;
        @(negedge clk); start = 1'b1; near_first = nf;
        @(negedge clk); start = 1'b0;
        while (!fin && cyc < 4000) begin
            near_first = 1'($urandom_range(0, 1));
            node_rsp_valid = 1'b0;
            node_child = $urandom; node_hit = 1'($urandom_range(0, 1));
            leaf_hit = 2'($urandom_range(0, 3)); leaf_start = $urandom; leaf_num = 16'($urandom);
            start = 1'b0;
            if (just_hs) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL %s valid_drop: out_valid=%b want 0", tag, out_valid);
                end
                just_hs = 0;
            end
            if (done) begin
                fin = 1;
            end else begin
                if (node_req) begin
                    if (!pending) begin
                        pending = 1; lat = $urandom_range(0, 3); waited = 0; held_idx = node_req_idx;
                    end else begin
                        n_cmp++;
                        if (node_req_idx !== held_idx) begin
                            n_fail++;
                            $display("FAIL %s req_idx_stable: got %0d want %0d", tag, node_req_idx, held_idx);
                        end
                    end
                    if (waited == lat) begin
                        node_rsp_valid = 1'b1; drive_node(int'(node_req_idx[3:0]));
                        got_f.push_back(int'(node_req_idx)); pending = 0;
                    end else begin
                        waited++;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    node_rsp_valid = 1'b1;
                end
                if (out_valid) begin
                    hold++;
                    cur_o = {out_start_prim[31:16], out_num_prim[15:8], out_start_prim[15:0], out_num_prim[7:0]};
                    n_cmp++;
                    if (node_req !== 1'b0) begin
                        n_fail++; $display("FAIL %s req_during_emit: node_req=%b want 0", tag, node_req);
                    end
                    if (hold > 1) begin
                        n_cmp++;
                        if (cur_o !== prev_o) begin
                            n_fail++; $display("FAIL %s out_stable: got %h want %h", tag, cur_o, prev_o);
                        end
                    end
                    prev_o = cur_o;
                    case (mode)
                        1:       out_ready = 1'b1;
                        2:       out_ready = (hold >= 11);
                        default: out_ready = 1'($urandom_range(0, 1));
                    endcase
                    if (out_ready) begin
                        got_p.push_back(cur_o); hold = 0; just_hs = 1;
                    end
                end else begin
                    hold = 0; out_ready = 1'($urandom_range(0, 1));
                end
                start = busy && ($urandom_range(0, 7) == 0);
                @(negedge clk); cyc++;
            end
        end
        start = 1'b0; out_ready = 1'b0; node_rsp_valid = 1'b0;
        n_cmp++;
        if (!fin) begin
            n_fail++; $display("FAIL %s timeout: done=%b after %0d cycles want 1", tag, done, cyc);
        end
        n_cmp++;
        if (got_f.size() != exp_fetch.size()) begin
            n_fail++; $display("FAIL %s fetch_count: got %0d want %0d", tag, got_f.size(), exp_fetch.size());
        end
        for (int i = 0; i < got_f.size() && i < exp_fetch.size(); i++) begin
            n_cmp++;
            if (got_f[i] != exp_fetch[i]) begin
                n_fail++; $display("FAIL %s fetch[%0d]: got %0d want %0d", tag, i, got_f[i], exp_fetch[i]);
            end
        end
        n_cmp++;
        if (got_p.size() != exp_pair.size()) begin
            n_fail++; $display("FAIL %s pair_count: got %0d want %0d", tag, got_p.size(), exp_pair.size());
        end
        for (int i = 0; i < got_p.size() && i < exp_pair.size(); i++) begin
            n_cmp++;
            if (got_p[i] !== exp_pair[i]) begin
                n_fail++; $display("FAIL %s pair[%0d]: got %h want %h", tag, i, got_p[i], exp_pair[i]);
            end
        end
        n_cmp++;
        if (overflow !== exp_ovf) begin
            n_fail++; $display("FAIL %s overflow: got %b want %b", tag, overflow, exp_ovf);
        end
        n_cmp++;
        if (node_count !== 16'(exp_cnt)) begin
            n_fail++; $display("FAIL %s node_count: got %0d want %0d", tag, node_count, exp_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s done_hold: done=%b busy=%b want 1/0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (node_req !== 1'b0 || node_req_idx !== 16'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: req=%b idx=%0d ov=%b want 0/0/0", node_req, node_req_idx, out_valid);
        end
        n_cmp++;
        if (out_start_prim !== 32'hFFFF_FFFF || out_num_prim !== 16'd0) begin
            n_fail++; $display("FAIL reset_out: start=%h num=%h want ffffffff/0000", out_start_prim, out_num_prim);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || node_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b ovf=%b cnt=%0d want 0", busy, done, overflow, node_count);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || node_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b done=%b req=%b want 0", busy, done, node_req);
        end
    endtask

    task automatic leaf_tree();
        clear_tree();
        t_nh[0] = 1'b1; t_c0[0] = 16'h8003; t_c1[0] = 16'd2; t_lh[0] = 2'b01;
        t_ls0[0] = 16'd40; t_ln0[0] = 8'd5; t_ln1[0] = 8'd7;
        t_nh[2] = 1'b1; t_c0[2] = 16'h8004; t_c1[2] = 16'h8005; t_lh[2] = 2'b00;
        t_ln0[2] = 8'd1; t_ln1[2] = 8'd1;
    endtask

    task automatic test_root_miss();
        clear_tree();
        run_ray(1'b0, 1, "root_miss");
    endtask

    task automatic test_leaf_pair();
        leaf_tree();
        run_ray(1'b0, 0, "leaf_pair");
    endtask

    task automatic test_near_first();
        clear_tree();
        t_nh[0] = 1'b1; t_c0[0] = 16'd1; t_c1[0] = 16'd2;
        run_ray(1'b1, 1, "near1");
        run_ray(1'b0, 0, "near0");
    endtask

    task automatic test_backpressure();
        leaf_tree();
        t_nh[2] = 1'b1; t_lh[2] = 2'b11;
        run_ray(1'b0, 2, "stall");
    endtask

    task automatic test_overflow();
        clear_tree();
        t_nh[0] = 1'b1; t_c0[0] = 16'd1; t_c1[0] = 16'd2;
        t_nh[1] = 1'b1; t_c0[1] = 16'd3; t_c1[1] = 16'd4;
        run_ray(1'b0, 1, "overflow");
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1 || done !== 1'b0 || node_count !== 16'd4) begin
            n_fail++;
            $display("FAIL abort_hold: ovf=%b done=%b cnt=%0d want 1/0/4", overflow, done, node_count);
        end
    endtask

    task automatic test_abort_fetch();
        leaf_tree();
        @(negedge clk); start = 1'b1; near_first = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (node_req !== 1'b1 || node_req_idx !== 16'd0) begin
            n_fail++; $display("FAIL abort_fetch_req: req=%b idx=%0d want 1/0", node_req, node_req_idx);
        end
        abort = 1'b1; node_rsp_valid = 1'b1; drive_node(0);
        @(negedge clk); abort = 1'b0; node_rsp_valid = 1'b0;
        n_cmp++;
        if (node_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || node_count !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_fetch: req=%b busy=%b done=%b ov=%b cnt=%0d want all 0",
                     node_req, busy, done, out_valid, node_count);
        end
        run_ray(1'b0, 0, "after_abort_fetch");
    endtask

    task automatic test_abort_emit();
        bit seen;
        leaf_tree();
        seen = 0;
        @(negedge clk); start = 1'b1; near_first = 1'b0; out_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            node_rsp_valid = 1'b0;
            if (out_valid) begin
                seen = 1;
            end else begin
                if (node_req) begin node_rsp_valid = 1'b1; drive_node(int'(node_req_idx[3:0])); end
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++; $display("FAIL abort_emit_reach: out_valid=%b want 1", out_valid);
        end
        @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk); abort = 1'b0; start = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || node_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || node_count !== 16'd1) begin
            n_fail++;
            $display("FAIL abort_emit: ov=%b req=%b busy=%b done=%b cnt=%0d want 0/0/0/0/1",
                     out_valid, node_req, busy, done, node_count);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_beats_start: busy=%b want 0", busy);
        end
        run_ray(1'b1, 0, "after_abort_emit");
    endtask

    task automatic test_random();
        bit nf;
        for (int r = 0; r < 25; r++) begin
            nf = 1'($urandom_range(0, 1));
            do begin
                gen_tree();
                run_model(nf);
            end while (exp_fetch.size() > 150);
            run_ray(nf, r % 3, $sformatf("rand%0d", r));
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0; near_first = 1'b0;
        node_rsp_valid = 1'b0; node_child = '0; node_hit = 1'b0; leaf_hit = '0;
        leaf_start = '0; leaf_num = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_root_miss();
        test_leaf_pair();
        test_near_first();
        test_backpressure();
        test_overflow();
        test_abort_fetch();
        test_abort_emit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
